ddr_rd_arb: RTL and testbench

- Round-robin arbiter that shares the single DDR read master between the frame-processing engines (rectifier, GFTT input buffer, and later stages).
- Each requester uses the same handshake: req/ack, then a 2-word command, then a returned data burst. The GFTT input buffer already uses this protocol.
- Grants one requester at a time and forwards its command to the master.
- Routes the returned burst back to the granted requester only, then releases the grant.

---
 rtl/ddr_rd_arb.sv | 217 +++++++++++++++++++++
 tb/tb_ddr_rd_arb.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_arb.sv
// Round-robin arbiter sharing one DDR read master among NREQ requesters (req/ack, 2-word command, data burst).
// Optional build macro DDR_RD_ARB_TMO_EN adds a no-progress watchdog that aborts a stalled grant.
module ddr_rd_arb #(
    parameter int NREQ  = 4,
    parameter int TMO_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enb,
    input  logic [NREQ-1:0]      req,
    output logic [NREQ-1:0]      ack,
    input  logic [NREQ-1:0]      cmd_v,
    input  logic [32*NREQ-1:0]   cmd_d,
    output logic [NREQ-1:0]      rd_v,
    output logic [31:0]          rd_d,
    output logic                 m_cmd_v,
    output logic [31:0]          m_cmd_d,
    input  logic                 m_rd_v,
    input  logic [31:0]          m_rd_d,
    output logic                 busy,
    output logic [2:0]           gnt_id,
    output logic                 err_orph,
    output logic                 err_tmo
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACK   = 3'd1,
        S_CMD_A = 3'd2,
        S_CMD_L = 3'd3,
        S_DATA  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [2:0]      gnt_q, gnt_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      beat_q, beat_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] rd_v_q, rd_v_d;
    logic [31:0]     rd_d_q, rd_d_d;
    logic            m_cmd_v_q, m_cmd_v_d;
    logic [31:0]     m_cmd_d_q, m_cmd_d_d;
    logic            err_orph_q, err_orph_d;

    logic            found;
    logic [IW-1:0]   win;
    int              idx;
    logic [IW-1:0]   gsel;
    logic [31:0]     cmd_word;

    assign gsel     = gnt_q[IW-1:0];
    assign cmd_word = cmd_d[{gsel, 5'd0} +: 32];

    // Rotating search: the port after the last winner has highest priority.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx[IW-1:0]]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
    end

`ifdef DDR_RD_ARB_TMO_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_tmo_q, err_tmo_d;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        len_d      = len_q;
        beat_d     = beat_q;
        ack_d      = '0;
        rd_v_d     = '0;
        rd_d_d     = rd_d_q;
        m_cmd_v_d  = 1'b0;
        m_cmd_d_d  = m_cmd_d_q;
        err_orph_d = err_orph_q;
`ifdef DDR_RD_ARB_TMO_EN
        tmo_d      = '0;
        err_tmo_d  = err_tmo_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    gnt_d      = 3'(win);
                    ack_d[win] = 1'b1;
                    state_d    = S_ACK;
                end
            end
            S_ACK: state_d = S_CMD_A;
            S_CMD_A: begin
                if (cmd_v[gsel]) begin
                    m_cmd_v_d = 1'b1;
                    m_cmd_d_d = cmd_word;
                    state_d   = S_CMD_L;
                end
            end
            S_CMD_L: begin
                if (cmd_v[gsel]) begin
                    m_cmd_v_d = 1'b1;
                    m_cmd_d_d = cmd_word;
                    len_d     = cmd_word[7:0];
                    beat_d    = 8'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (m_rd_v) begin
                    rd_v_d[gsel] = 1'b1;
                    rd_d_d       = m_rd_d;
                    beat_d       = beat_q + 8'd1;
                    if (beat_q == len_q) begin
                        ptr_d   = gnt_q;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Beats outside DATA belong to nobody; they are discarded and flagged.
        if (m_rd_v && state_q != S_DATA) err_orph_d = 1'b1;

`ifdef DDR_RD_ARB_TMO_EN
        if (state_q == S_CMD_A || state_q == S_CMD_L || state_q == S_DATA) begin
            if (cmd_v[gsel] || m_rd_v) begin
                tmo_d = '0;
            end else if (&tmo_q) begin
                err_tmo_d = 1'b1;
                ptr_d     = gnt_q;
                state_d   = S_IDLE;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif

        if (!enb) begin
            state_d    = S_IDLE;
            ack_d      = '0;
            rd_v_d     = '0;
            m_cmd_v_d  = 1'b0;
            ptr_d      = 3'd0;
            err_orph_d = 1'b0;
`ifdef DDR_RD_ARB_TMO_EN
            tmo_d      = '0;
            err_tmo_d  = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= 3'd0;
            gnt_q      <= 3'd0;
            len_q      <= 8'd0;
            beat_q     <= 8'd0;
            ack_q      <= '0;
            rd_v_q     <= '0;
            rd_d_q     <= 32'd0;
            m_cmd_v_q  <= 1'b0;
            m_cmd_d_q  <= 32'd0;
            err_orph_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            ack_q      <= ack_d;
            rd_v_q     <= rd_v_d;
            rd_d_q     <= rd_d_d;
            m_cmd_v_q  <= m_cmd_v_d;
            m_cmd_d_q  <= m_cmd_d_d;
            err_orph_q <= err_orph_d;
        end
    end

`ifdef DDR_RD_ARB_TMO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q     <= '0;
            err_tmo_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            err_tmo_q <= err_tmo_d;
        end
    end
    assign err_tmo = err_tmo_q;
`else
    // No watchdog: a stalled requester holds the grant until enb drops.
    assign err_tmo = 1'b0 && (TMO_W > 0);
`endif

    assign ack      = ack_q;
    assign rd_v     = rd_v_q;
    assign rd_d     = rd_d_q;
    assign m_cmd_v  = m_cmd_v_q;
    assign m_cmd_d  = m_cmd_d_q;
    assign busy     = (state_q != S_IDLE);
    assign gnt_id   = gnt_q;
    assign err_orph = err_orph_q;

endmodule

// File: tb/tb_ddr_rd_arb.sv
// Directed self-checking bench for ddr_rd_arb (NREQ=4); covers the watchdog when DDR_RD_ARB_TMO_EN is defined.
module tb_ddr_rd_arb;

`ifdef DDR_RD_ARB_TMO_EN
    localparam int TMO_W = 4;
`else
    localparam int TMO_W = 16;
`endif

    logic         clk;
    logic         rst_n;
    logic         enb;
    logic [3:0]   req;
    logic [3:0]   ack;
    logic [3:0]   cmd_v;
    logic [127:0] cmd_d;
    logic [3:0]   rd_v;
    logic [31:0]  rd_d;
    logic         m_cmd_v;
    logic [31:0]  m_cmd_d;
    logic         m_rd_v;
    logic [31:0]  m_rd_d;
    logic         busy;
    logic [2:0]   gnt_id;
    logic         err_orph;
    logic         err_tmo;

    int checks = 0;
    int errors = 0;

    ddr_rd_arb #(.NREQ(4), .TMO_W(TMO_W)) dut (
        .clk(clk), .rst_n(rst_n), .enb(enb), .req(req), .ack(ack),
        .cmd_v(cmd_v), .cmd_d(cmd_d), .rd_v(rd_v), .rd_d(rd_d),
        .m_cmd_v(m_cmd_v), .m_cmd_d(m_cmd_d), .m_rd_v(m_rd_v), .m_rd_d(m_rd_d),
        .busy(busy), .gnt_id(gnt_id), .err_orph(err_orph), .err_tmo(err_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request a single port and step past ACK into CMD_A.
    task automatic grant_port(input int p);
        req = 4'(1 << p);
        tick();
        req = 4'b0000;
        tick();
    endtask

    // Send address then length word from port p, leaving the arbiter in DATA.
    task automatic send_cmd(input int p, input logic [31:0] addr, input logic [31:0] lenw);
        cmd_v = 4'(1 << p);
        cmd_d[32*p +: 32] = addr;
        tick();
        cmd_d[32*p +: 32] = lenw;
        tick();
        cmd_v = 4'b0000;
        cmd_d = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enb = 1'b0; req = '0; cmd_v = '0; cmd_d = '0; m_rd_v = 1'b0; m_rd_d = '0;
        tick(); tick(); tick();
        checks++;
        if ({ack, rd_v, rd_d, m_cmd_v, m_cmd_d, busy, gnt_id, err_orph, err_tmo} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ack=%h rd_v=%h rd_d=%h m_cmd_v=%b m_cmd_d=%h busy=%b gnt=%0d orph=%b tmo=%b want all 0",
                     ack, rd_v, rd_d, m_cmd_v, m_cmd_d, busy, gnt_id, err_orph, err_tmo);
        end
        rst_n = 1'b1;
        enb = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        req = 4'b0010;
        tick();
        checks++;
        if (ack !== 4'b0010) begin errors++; $display("FAIL basic_ack got %h want 2", ack); end
        checks++;
        if (busy !== 1'b1 || gnt_id !== 3'd1) begin errors++; $display("FAIL basic_grant got busy=%b gnt=%0d want busy=1 gnt=1", busy, gnt_id); end
        req = 4'b0000;
        tick();
        checks++;
        if (ack !== 4'b0000) begin errors++; $display("FAIL basic_ack_pulse got %h want 0", ack); end
        cmd_v = 4'b0010;
        cmd_d[63:32] = 32'h1230_0000;
        tick();
        checks++;
        if (m_cmd_v !== 1'b1 || m_cmd_d !== 32'h1230_0000) begin
            errors++; $display("FAIL basic_addr got v=%b d=%h want v=1 d=12300000", m_cmd_v, m_cmd_d);
        end
        cmd_d[63:32] = 32'h0000_0003;
        tick();
        checks++;
        if (m_cmd_v !== 1'b1 || m_cmd_d !== 32'h0000_0003) begin
            errors++; $display("FAIL basic_len got v=%b d=%h want v=1 d=00000003", m_cmd_v, m_cmd_d);
        end
        cmd_v = 4'b0000;
        cmd_d = '0;
        for (int i = 0; i < 4; i++) begin
            m_rd_v = 1'b1;
            m_rd_d = 32'hA0 + 32'(i);
            tick();
            checks++;
            if (rd_v !== 4'b0010 || rd_d !== 32'hA0 + 32'(i)) begin
                errors++; $display("FAIL basic_beat%0d got rd_v=%h rd_d=%h want rd_v=2 rd_d=%h", i, rd_v, rd_d, 32'hA0 + 32'(i));
            end
            checks++;
            if (busy !== (i < 3)) begin errors++; $display("FAIL basic_busy%0d got %b want %b", i, busy, (i < 3)); end
        end
        m_rd_v = 1'b0;
        tick();
        checks++;
        if (rd_v !== 4'b0000 || m_cmd_v !== 1'b0 || err_orph !== 1'b0) begin
            errors++; $display("FAIL basic_quiet got rd_v=%h m_cmd_v=%b orph=%b want 0 0 0", rd_v, m_cmd_v, err_orph);
        end
    endtask

    task automatic test_round_robin();
        enb = 1'b0;
        tick();
        enb = 1'b1;
        req = 4'b1111;
        for (int b = 0; b < 4; b++) begin
            int e;
            e = (b + 1) % 4;
            tick();
            checks++;
            if (gnt_id !== 3'(e) || ack !== 4'(1 << e)) begin
                errors++; $display("FAIL rr_grant%0d got gnt=%0d ack=%h want gnt=%0d ack=%h", b, gnt_id, ack, e, 4'(1 << e));
            end
            tick();
            send_cmd(e, 32'h4000_0000 + 32'(e), 32'h0000_0000);
            m_rd_v = 1'b1;
            m_rd_d = 32'(b);
            tick();
            checks++;
            if (rd_v !== 4'(1 << e) || busy !== 1'b0) begin
                errors++; $display("FAIL rr_done%0d got rd_v=%h busy=%b want rd_v=%h busy=0", b, rd_v, busy, 4'(1 << e));
            end
            m_rd_v = 1'b0;
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_cmd_filter();
        req = 4'b0100;
        tick();
        checks++;
        if (gnt_id !== 3'd2) begin errors++; $display("FAIL filt_grant got %0d want 2", gnt_id); end
        req = 4'b0000;
        tick();
        cmd_v = 4'b0001;
        cmd_d[31:0] = 32'hDEAD_BEEF;
        tick();
        checks++;
        if (m_cmd_v !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL filt_ignored got m_cmd_v=%b busy=%b want 0 1", m_cmd_v, busy);
        end
        cmd_v = 4'b0101;
        cmd_d[95:64] = 32'h2220_0000;
        tick();
        checks++;
        if (m_cmd_v !== 1'b1 || m_cmd_d !== 32'h2220_0000) begin
            errors++; $display("FAIL filt_addr got v=%b d=%h want v=1 d=22200000", m_cmd_v, m_cmd_d);
        end
        cmd_d[95:64] = 32'h0000_1100;
        tick();
        checks++;
        if (m_cmd_d !== 32'h0000_1100) begin errors++; $display("FAIL filt_len got %h want 00001100", m_cmd_d); end
        cmd_v = 4'b0000;
        cmd_d = '0;
        m_rd_v = 1'b1;
        m_rd_d = 32'h77;
        tick();
        checks++;
        if (rd_v !== 4'b0100 || rd_d !== 32'h77 || busy !== 1'b0) begin
            errors++; $display("FAIL filt_beat got rd_v=%h rd_d=%h busy=%b want 4 77 0", rd_v, rd_d, busy);
        end
        m_rd_v = 1'b0;
        tick();
    endtask

    task automatic test_orphan();
        m_rd_v = 1'b1;
        m_rd_d = 32'h55;
        tick();
        checks++;
        if (rd_v !== 4'b0000 || err_orph !== 1'b1) begin
            errors++; $display("FAIL orph_set got rd_v=%h orph=%b want 0 1", rd_v, err_orph);
        end
        m_rd_v = 1'b0;
        tick();
        checks++;
        if (err_orph !== 1'b1) begin errors++; $display("FAIL orph_sticky got %b want 1", err_orph); end
        enb = 1'b0;
        tick();
        enb = 1'b1;
        tick();
        checks++;
        if (err_orph !== 1'b0) begin errors++; $display("FAIL orph_clear got %b want 0", err_orph); end
    endtask

    task automatic test_enb_drop();
        req = 4'b1000;
        tick();
        checks++;
        if (gnt_id !== 3'd3) begin errors++; $display("FAIL enb_grant got %0d want 3", gnt_id); end
        req = 4'b0000;
        tick();
        send_cmd(3, 32'h3000_0000, 32'h0000_0007);
        m_rd_v = 1'b1;
        tick();
        tick();
        enb = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || rd_v !== 4'b0000 || ack !== 4'b0000) begin
            errors++; $display("FAIL enb_idle got busy=%b rd_v=%h ack=%h want 0 0 0", busy, rd_v, ack);
        end
        m_rd_v = 1'b0;
        enb = 1'b1;
        tick();
        req = 4'b0001;
        tick();
        checks++;
        if (ack !== 4'b0001 || gnt_id !== 3'd0) begin
            errors++; $display("FAIL enb_regrant got ack=%h gnt=%0d want 1 0", ack, gnt_id);
        end
        req = 4'b0000;
        tick();
        send_cmd(0, 32'h0000_1000, 32'h0000_0000);
        m_rd_v = 1'b1;
        m_rd_d = 32'h99;
        tick();
        checks++;
        if (rd_v !== 4'b0001 || busy !== 1'b0) begin
            errors++; $display("FAIL enb_burst got rd_v=%h busy=%b want 1 0", rd_v, busy);
        end
        m_rd_v = 1'b0;
        tick();
    endtask

    task automatic test_long_burst();
        grant_port(1);
        send_cmd(1, 32'h5550_0000, 32'h0000_00FF);
        for (int i = 0; i < 256; i++) begin
            m_rd_v = 1'b1;
            m_rd_d = 32'(i);
            tick();
            checks++;
            if (rd_v !== 4'b0010 || rd_d !== 32'(i) || busy !== (i < 255)) begin
                errors++; $display("FAIL long_beat%0d got rd_v=%h rd_d=%h busy=%b want 2 %h %b", i, rd_v, rd_d, busy, 32'(i), (i < 255));
            end
        end
        m_rd_v = 1'b0;
        tick();
        checks++;
        if (err_orph !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL long_end got orph=%b busy=%b want 0 0", err_orph, busy);
        end
    endtask

    task automatic test_watchdog();
        grant_port(3);
`ifdef DDR_RD_ARB_TMO_EN
        for (int n = 0; n < 40 && busy; n++) tick();
        checks++;
        if (busy !== 1'b0 || err_tmo !== 1'b1) begin
            errors++; $display("FAIL tmo_abort got busy=%b err_tmo=%b want 0 1", busy, err_tmo);
        end
        req = 4'b0001;
        tick();
        checks++;
        if (ack !== 4'b0001 || gnt_id !== 3'd0) begin
            errors++; $display("FAIL tmo_regrant got ack=%h gnt=%0d want 1 0", ack, gnt_id);
        end
        req = 4'b0000;
`else
        repeat (20) tick();
        checks++;
        if (busy !== 1'b1 || err_tmo !== 1'b0 || gnt_id !== 3'd3) begin
            errors++; $display("FAIL tmo_waits got busy=%b err_tmo=%b gnt=%0d want 1 0 3", busy, err_tmo, gnt_id);
        end
`endif
        enb = 1'b0;
        tick();
        enb = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || err_tmo !== 1'b0) begin
            errors++; $display("FAIL tmo_cleanup got busy=%b err_tmo=%b want 0 0", busy, err_tmo);
        end
    endtask

    task automatic test_reset_mid();
        grant_port(2);
        send_cmd(2, 32'h6000_0000, 32'h0000_0003);
        m_rd_v = 1'b1;
        m_rd_d = 32'hCC;
        tick();
        tick();
        m_rd_v = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ack, rd_v, rd_d, m_cmd_v, m_cmd_d, busy, gnt_id, err_orph, err_tmo} !== '0) begin
            errors++;
            $display("FAIL rst_mid got ack=%h rd_v=%h rd_d=%h m_cmd_v=%b m_cmd_d=%h busy=%b gnt=%0d want all 0",
                     ack, rd_v, rd_d, m_cmd_v, m_cmd_d, busy, gnt_id);
        end
        tick();
        rst_n = 1'b1;
        tick();
        req = 4'b0001;
        tick();
        checks++;
        if (ack !== 4'b0001 || gnt_id !== 3'd0) begin
            errors++; $display("FAIL rst_regrant got ack=%h gnt=%0d want 1 0", ack, gnt_id);
        end
        req = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_cmd_filter();
        test_orphan();
        test_enb_drop();
        test_long_burst();
        test_watchdog();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
